// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART receiver types and default frame geometry
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } uart_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : 2-flop synchronizer for an asynchronous single-bit input
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module uart_rx_sync
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : oversampled 8-N-1 receiver; UART_RX_PARITY_EN adds an even parity bit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = RX_IDLE;
  localparam logic [2:0] START  = RX_START;
  localparam logic [2:0] DATA   = RX_DATA;
  localparam logic [2:0] STOP   = RX_STOP;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = RX_PARITY;
`endif

  logic                 rx_s;
  logic [2:0]           state;
  logic                 armed;
  logic [SW-1:0]        s_cnt;
  logic [NW-1:0]        n_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Even parity: data bits plus parity bit must hold an even count of ones.
  assign par_bad = ^{shift, par_bit};
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      s_cnt     <= '0;
      n_cnt     <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) begin
        case (state)
          IDLE: begin
            // A high line re-arms start detection after reset or a break.
            if (rx_s) armed <= 1'b1;
            if (armed && !rx_s) begin
              state <= START;
              s_cnt <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (s_cnt == S_HALF) begin
              s_cnt <= '0;
              n_cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          DATA: begin
            if (s_cnt == S_LAST) begin
              shift <= {rx_s, shift[DATA_BITS-1:1]};
              s_cnt <= '0;
              if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n_cnt <= n_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (s_cnt == S_LAST) begin
              par_bit <= rx_s;
              s_cnt   <= '0;
              state   <= STOP;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (s_cnt == S_LAST) begin
              // Leave at mid stop bit so the next start edge is caught cleanly.
              data  <= shift;
              s_cnt <= '0;
              state <= IDLE;
              busy  <= 1'b0;
              if (rx_s) begin
                valid <= !par_bad;
`ifdef UART_RX_PARITY_EN
                parity_err <= par_bad;
`endif
              end else begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : randomized self-checking bench for uart_rx (honours UART_RX_PARITY_EN)
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int TICK_DIV = 14;
  localparam int OS       = 16;
  localparam int NB       = 8;
  localparam int BIT_CLKS = TICK_DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LAT_MIN  = BIT_CLKS * (NB + 1 + PAR_BITS) + BIT_CLKS / 2;
  localparam int LAT_MAX  = LAT_MIN + TICK_DIV + 8;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          tick  = 1'b0;
  logic          rx    = 1'b1;
  logic [NB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  uart_rx #(
    .DATA_BITS  (NB),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      tick = (c == TICK_DIV - 1);
      c = (c == TICK_DIV - 1) ? 0 : c + 1;
    end
  end

  typedef struct {
    int          kind;
    logic [7:0]  d;
    int          cyc;
  } ev_t;

  ev_t ev_q[$];
  int  cyc;
  int  width_bad;
  int  excl_bad;
  int  busy_cycles;
  logic pv, pf, pp;
  int  last_start;
  int  n_cmp;
  int  n_mis;

  initial begin
    cyc = 0; width_bad = 0; excl_bad = 0; busy_cycles = 0;
    pv = 1'b0; pf = 1'b0; pp = 1'b0;
  end

  function automatic ev_t mk_ev(input int k, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.d    = d;
    e.cyc  = c;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: one entry per status pulse, plus pulse-shape bookkeeping.
  always @(negedge clk) begin
    if (valid)      ev_q.push_back(mk_ev(K_VALID, data, cyc));
    if (frame_err)  ev_q.push_back(mk_ev(K_FERR, data, cyc));
    if (parity_err) ev_q.push_back(mk_ev(K_PERR, data, cyc));
    if ((valid && pv) || (frame_err && pf) || (parity_err && pp)) width_bad <= width_bad + 1;
    if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) excl_bad <= excl_bad + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    pv <= valid;
    pf <= frame_err;
    pp <= parity_err;
  end

  // Reference model: outcome of a frame from its stop bit and parity rule.
  function automatic int expect_kind(input logic [7:0] b, input logic stop_v, input logic par_v);
    logic par_ok;
    par_ok = ((^b) == par_v) || (PAR_BITS == 0);
    if (!stop_v) return K_FERR;
    if (!par_ok) return K_PERR;
    return K_VALID;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v,
                            input int gap_bits);
    rx = 1'b0;
    last_start = cyc;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (PAR_BITS == 1) begin
      rx = par_v;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_v;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (gap_bits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_reset;
    int base;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (data !== 8'h00)     begin n_mis++; $display("FAIL reset_data: got %0h want 0", data); end
    n_cmp++; if (valid !== 1'b0)     begin n_mis++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_mis++; $display("FAIL reset_ferr: got %0b want 0", frame_err); end
    n_cmp++; if (parity_err !== 1'b0) begin n_mis++; $display("FAIL reset_perr: got %0b want 0", parity_err); end
    n_cmp++; if (busy !== 1'b0)      begin n_mis++; $display("FAIL reset_busy: got %0b want 0", busy); end
    base = ev_q.size();
    reset = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)      begin n_mis++; $display("FAIL idle_busy: got %0b want 0", busy); end
    n_cmp++; if (ev_q.size() - base !== 0) begin n_mis++; $display("FAIL idle_events: got %0d want 0", ev_q.size() - base); end
  endtask

  task automatic test_good_frames;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      logic       p;
      int         base;
      int         ek;
      int         lat;
      b    = (i == 0) ? 8'hA5 : 8'($urandom);
      p    = (i < 2) ? ^b : 1'($urandom_range(0, 1));
      ek   = expect_kind(b, 1'b1, p);
      base = ev_q.size();
      send_frame(b, 1'b1, p, 1);
      n_cmp++;
      if (ev_q.size() - base !== 1) begin
        n_mis++; $display("FAIL good_count[%0d]: got %0d events want 1", i, ev_q.size() - base);
      end else begin
        lat = ev_q[base].cyc - last_start;
        n_cmp++; if (ev_q[base].kind !== ek) begin n_mis++; $display("FAIL good_kind[%0d]: got %0d want %0d", i, ev_q[base].kind, ek); end
        n_cmp++; if (ev_q[base].d !== b)     begin n_mis++; $display("FAIL good_data[%0d]: got %0h want %0h", i, ev_q[base].d, b); end
        n_cmp++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_mis++; $display("FAIL good_latency[%0d]: got %0d want %0d..%0d", i, lat, LAT_MIN, LAT_MAX); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL good_busy[%0d]: got %0b want 0", i, busy); end
      n_cmp++; if (data !== b)    begin n_mis++; $display("FAIL good_hold[%0d]: got %0h want %0h", i, data, b); end
    end
  endtask

  task automatic test_frame_error;
    int base;
    base = ev_q.size();
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    n_cmp++;
    if (ev_q.size() - base !== 1) begin
      n_mis++; $display("FAIL ferr_count: got %0d want 1", ev_q.size() - base);
    end else begin
      n_cmp++; if (ev_q[base].kind !== K_FERR) begin n_mis++; $display("FAIL ferr_kind: got %0d want %0d", ev_q[base].kind, K_FERR); end
    end
    n_cmp++; if (data !== 8'h3C) begin n_mis++; $display("FAIL ferr_data: got %0h want 3c", data); end
    base = ev_q.size();
    send_frame(8'h55, 1'b1, 1'b0, 1);
    n_cmp++;
    if (ev_q.size() - base !== 1) begin
      n_mis++; $display("FAIL after_ferr_count: got %0d want 1", ev_q.size() - base);
    end else begin
      n_cmp++; if (ev_q[base].kind !== K_VALID) begin n_mis++; $display("FAIL after_ferr_kind: got %0d want %0d", ev_q[base].kind, K_VALID); end
      n_cmp++; if (ev_q[base].d !== 8'h55)      begin n_mis++; $display("FAIL after_ferr_data: got %0h want 55", ev_q[base].d); end
    end
  endtask

  task automatic test_glitch;
    int base;
    int b0;
    base = ev_q.size();
    b0   = busy_cycles;
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_cmp++; if (ev_q.size() - base !== 0) begin n_mis++; $display("FAIL glitch_events: got %0d want 0", ev_q.size() - base); end
    n_cmp++; if (busy_cycles - b0 < 1 || busy_cycles - b0 > BIT_CLKS) begin
      n_mis++; $display("FAIL glitch_busy_pulse: got %0d busy cycles want 1..%0d", busy_cycles - b0, BIT_CLKS);
    end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL glitch_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_reset_midframe;
    int base;
    logic [7:0] f0;
    f0 = 8'hF0;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = f0[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL midframe_busy: got %0b want 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (data !== 8'h00)      begin n_mis++; $display("FAIL rst_mid_data: got %0h want 0", data); end
    n_cmp++; if (busy !== 1'b0)       begin n_mis++; $display("FAIL rst_mid_busy: got %0b want 0", busy); end
    n_cmp++; if ({valid, frame_err, parity_err} !== 3'b000) begin
      n_mis++; $display("FAIL rst_mid_pulses: got %0b want 000", {valid, frame_err, parity_err});
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    base = ev_q.size();
    send_frame(8'h81, 1'b1, ^8'h81, 1);
    n_cmp++;
    if (ev_q.size() - base !== 1) begin
      n_mis++; $display("FAIL post_rst_count: got %0d want 1", ev_q.size() - base);
    end else begin
      n_cmp++; if (ev_q[base].kind !== K_VALID) begin n_mis++; $display("FAIL post_rst_kind: got %0d want %0d", ev_q[base].kind, K_VALID); end
      n_cmp++; if (ev_q[base].d !== 8'h81)      begin n_mis++; $display("FAIL post_rst_data: got %0h want 81", ev_q[base].d); end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      int         base;
      a    = (i == 0) ? 8'h00 : 8'($urandom);
      b    = (i == 0) ? 8'hFF : 8'($urandom);
      base = ev_q.size();
      send_frame(a, 1'b1, ^a, 0);
      send_frame(b, 1'b1, ^b, 1);
      n_cmp++;
      if (ev_q.size() - base !== 2) begin
        n_mis++; $display("FAIL b2b_count[%0d]: got %0d want 2", i, ev_q.size() - base);
      end else begin
        n_cmp++; if (ev_q[base].kind !== K_VALID || ev_q[base+1].kind !== K_VALID) begin
          n_mis++; $display("FAIL b2b_kind[%0d]: got %0d,%0d want 0,0", i, ev_q[base].kind, ev_q[base+1].kind);
        end
        n_cmp++; if (ev_q[base].d !== a)   begin n_mis++; $display("FAIL b2b_first[%0d]: got %0h want %0h", i, ev_q[base].d, a); end
        n_cmp++; if (ev_q[base+1].d !== b) begin n_mis++; $display("FAIL b2b_second[%0d]: got %0h want %0h", i, ev_q[base+1].d, b); end
      end
      n_cmp++; if (data !== b) begin n_mis++; $display("FAIL b2b_hold[%0d]: got %0h want %0h", i, data, b); end
    end
  endtask

  task automatic test_break;
    int base;
    logic [7:0] b;
    base = ev_q.size();
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    n_cmp++;
    if (ev_q.size() - base !== 1) begin
      n_mis++; $display("FAIL break_count: got %0d want 1", ev_q.size() - base);
    end else begin
      n_cmp++; if (ev_q[base].kind !== K_FERR) begin n_mis++; $display("FAIL break_kind: got %0d want %0d", ev_q[base].kind, K_FERR); end
    end
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    b    = 8'($urandom);
    base = ev_q.size();
    send_frame(b, 1'b1, ^b, 1);
    n_cmp++;
    if (ev_q.size() - base !== 1) begin
      n_mis++; $display("FAIL after_break_count: got %0d want 1", ev_q.size() - base);
    end else begin
      n_cmp++; if (ev_q[base].d !== b) begin n_mis++; $display("FAIL after_break_data: got %0h want %0h", ev_q[base].d, b); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    for (int i = 0; i < 2; i++) begin
      logic p;
      int   base;
      int   ek;
      p    = (i == 0) ? 1'b1 : 1'b0;
      ek   = expect_kind(8'h07, 1'b1, p);
      base = ev_q.size();
      send_frame(8'h07, 1'b1, p, 1);
      n_cmp++;
      if (ev_q.size() - base !== 1) begin
        n_mis++; $display("FAIL par_count[%0d]: got %0d want 1", i, ev_q.size() - base);
      end else begin
        n_cmp++; if (ev_q[base].kind !== ek) begin n_mis++; $display("FAIL par_kind[%0d]: got %0d want %0d", i, ev_q[base].kind, ek); end
      end
      n_cmp++; if (data !== 8'h07) begin n_mis++; $display("FAIL par_data[%0d]: got %0h want 07", i, data); end
    end
  endtask
`endif

  task automatic test_pulse_shape;
    n_cmp++; if (width_bad !== 0) begin n_mis++; $display("FAIL pulse_width: got %0d long pulses want 0", width_bad); end
    n_cmp++; if (excl_bad !== 0)  begin n_mis++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", excl_bad); end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    last_start = 0;
    @(negedge clk);
    test_reset();
    test_good_frames();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_pulse_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
